// File: rtl/pc_gen_if.sv
// pc_gen_if
// Bundles the fetch handshake (toward instruction memory) and the redirect
// request (from execute) that the program-counter generator works with.
//
// Signals:
//   fetch_addr   PC presented to instruction memory
//   fetch_valid  fetch_addr is a live request
//   fetch_ready  memory accepts the request this cycle
//   fetch_flush  one-cycle pulse squashing the outstanding request
//   redir_valid  one-cycle redirect pulse from execute
//   redir_mode   0 = BRANCH, 1 = JALR, 2 = TRAP, 3 = MRET
//   pc_execute   PC of the redirecting instruction
//   imm          immediate operand
//   reg1         rs1 operand
//
// Modports:
//   master  the PC generator side
//   slave   the memory / execute side
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] fetch_addr;
    logic            fetch_valid;
    logic            fetch_ready;
    logic            fetch_flush;
    logic            redir_valid;
    logic [1:0]      redir_mode;
    logic [XLEN-1:0] pc_execute;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] reg1;

    modport master (
        output fetch_addr,
        output fetch_valid,
        output fetch_flush,
        input  fetch_ready,
        input  redir_valid,
        input  redir_mode,
        input  pc_execute,
        input  imm,
        input  reg1
    );

    modport slave (
        input  fetch_addr,
        input  fetch_valid,
        input  fetch_flush,
        output fetch_ready,
        output redir_valid,
        output redir_mode,
        output pc_execute,
        output imm,
        output reg1
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen
// Fetch-stage program-counter generator. Holds the fetch PC, offers it to
// instruction memory over a valid/ready handshake and selects the next PC
// from sequential, branch, JALR, trap and return sources. Redirects that
// arrive while the pipeline is stalled are parked in a pending register and
// applied on the first enabled cycle. Misaligned BRANCH/JALR targets are
// turned into a trap to the trap vector with the exception PC saved.
//
// Ports:
//   clk               clock, rising edge
//   rst               asynchronous active-high reset
//   i_en              pipeline enable; 0 freezes state except redirect capture
//   i_trap_vector     trap handler address
//   o_epc             saved exception PC
//   o_misalign_fault  one-cycle pulse after a misaligned redirect
//   o_bad_addr        last misaligned target
//   bus               fetch handshake + redirect request (master side)
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              ALIGN_BITS   = 2,
    parameter int              INC          = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic [XLEN-1:0] i_trap_vector,
    output logic [XLEN-1:0] o_epc,
    output logic            o_misalign_fault,
    output logic [XLEN-1:0] o_bad_addr,
    pc_gen_if.master        bus
);

    typedef enum logic [1:0] {
        MODE_BRANCH = 2'd0,
        MODE_JALR   = 2'd1,
        MODE_TRAP   = 2'd2,
        MODE_MRET   = 2'd3
    } redir_mode_e;

    // Low target bits that must be zero for a legal control-flow target.
    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
    localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);

    logic [XLEN-1:0] r_pc;
    logic            r_fetchValid;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_badAddr;
    logic            r_misalignFault;

    logic            r_pendValid;
    redir_mode_e     r_pendMode;
    logic [XLEN-1:0] r_pendPc;
    logic [XLEN-1:0] r_pendImm;
    logic [XLEN-1:0] r_pendReg1;

    logic            w_effValid;
    redir_mode_e     w_effMode;
    logic [XLEN-1:0] w_effPc;
    logic [XLEN-1:0] w_effImm;
    logic [XLEN-1:0] w_effReg1;
    logic [XLEN-1:0] w_jalrSum;
    logic [XLEN-1:0] w_target;
    logic            w_misaligned;

    // Effective redirect: a live pulse always beats a parked one, so the
    // newest control-flow decision is the one that is applied. The target is
    // then formed per mode; JALR drops bit 0 before the alignment check, and
    // only BRANCH/JALR targets are checked (TRAP/MRET addresses are trusted).
    always_comb begin
        w_effValid = bus.redir_valid | r_pendValid;
        w_effMode  = r_pendMode;
        w_effPc    = r_pendPc;
        w_effImm   = r_pendImm;
        w_effReg1  = r_pendReg1;
        if (bus.redir_valid) begin
            w_effMode = redir_mode_e'(bus.redir_mode);
            w_effPc   = bus.pc_execute;
            w_effImm  = bus.imm;
            w_effReg1 = bus.reg1;
        end

        w_jalrSum = w_effReg1 + w_effImm;
        w_target  = w_effPc + w_effImm;
        case (w_effMode)
            MODE_BRANCH: w_target = w_effPc + w_effImm;
            MODE_JALR:   w_target = {w_jalrSum[XLEN-1:1], 1'b0};
            MODE_TRAP:   w_target = i_trap_vector;
            MODE_MRET:   w_target = r_epc;
            default:     w_target = w_effPc + w_effImm;
        endcase

        w_misaligned = ((w_effMode == MODE_BRANCH) || (w_effMode == MODE_JALR))
                       && ((w_target & ALIGN_MASK) != '0);
    end

    // The flush squashes the request in the same cycle the redirect is seen,
    // so the memory never acts on a fetch from the wrong path.
    assign bus.fetch_flush = i_en & w_effValid & r_fetchValid;

    // PC, exception state and pending-redirect register. While stalled only
    // the pending register moves; once enabled the effective redirect takes
    // priority over the sequential advance, and the pending slot is always
    // emptied because it has either been applied or superseded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc            <= RESET_VECTOR;
            r_fetchValid    <= 1'b0;
            r_epc           <= '0;
            r_badAddr       <= '0;
            r_misalignFault <= 1'b0;
            r_pendValid     <= 1'b0;
            r_pendMode      <= MODE_BRANCH;
            r_pendPc        <= '0;
            r_pendImm       <= '0;
            r_pendReg1      <= '0;
        end else if (i_en) begin
            r_fetchValid    <= 1'b1;
            r_pendValid     <= 1'b0;
            r_misalignFault <= 1'b0;
            if (w_effValid) begin
                if (w_misaligned) begin
                    r_pc            <= i_trap_vector;
                    r_epc           <= w_effPc;
                    r_badAddr       <= w_target;
                    r_misalignFault <= 1'b1;
                end else begin
                    r_pc <= w_target;
                    if (w_effMode == MODE_TRAP) begin
                        r_epc <= w_effPc;
                    end
                end
            end else if (r_fetchValid && bus.fetch_ready) begin
                r_pc <= r_pc + INC_W;
            end
        end else begin
            r_misalignFault <= 1'b0;
            if (bus.redir_valid) begin
                r_pendValid <= 1'b1;
                r_pendMode  <= redir_mode_e'(bus.redir_mode);
                r_pendPc    <= bus.pc_execute;
                r_pendImm   <= bus.imm;
                r_pendReg1  <= bus.reg1;
            end
        end
    end

    assign bus.fetch_addr  = r_pc;
    assign bus.fetch_valid = r_fetchValid;
    assign o_epc            = r_epc;
    assign o_bad_addr       = r_badAddr;
    assign o_misalign_fault = r_misalignFault;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen
// Scoreboard bench for pc_gen. Stimulus pushes the hand-computed expected
// outputs for the current cycle into a queue; a monitor on the falling edge
// pops each entry and compares it against the selected DUT instance.
// Instance 0 uses ALIGN_BITS = 2, instance 1 uses ALIGN_BITS = 1.
module tb_pc_gen;

    localparam logic [1:0] M_BR   = 2'd0;
    localparam logic [1:0] M_JALR = 2'd1;
    localparam logic [1:0] M_TRAP = 2'd2;
    localparam logic [1:0] M_MRET = 2'd3;

    typedef struct {
        string       name;
        int          inst;
        logic [31:0] addr;
        logic        valid;
        logic        flush;
        logic [31:0] epc;
        logic [31:0] bad;
        logic        mf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en0;
    logic        en1;
    logic [31:0] tv0;
    logic [31:0] tv1;
    logic [31:0] epc0;
    logic [31:0] epc1;
    logic [31:0] bad0;
    logic [31:0] bad1;
    logic        mf0;
    logic        mf1;

    exp_t        sbQ[$];
    int          checks;
    int          passes;
    logic [31:0] xEpc;
    logic [31:0] xBad;

    exp_t        e;
    logic [31:0] aAddr;
    logic        aValid;
    logic        aFlush;
    logic [31:0] aEpc;
    logic [31:0] aBad;
    logic        aMf;

    pc_gen_if #(.XLEN(32)) bus0 ();
    pc_gen_if #(.XLEN(32)) bus1 ();

    pc_gen #(
        .XLEN(32), .RESET_VECTOR(32'h0), .ALIGN_BITS(2), .INC(4)
    ) dut0 (
        .clk(clk), .rst(rst), .i_en(en0), .i_trap_vector(tv0),
        .o_epc(epc0), .o_misalign_fault(mf0), .o_bad_addr(bad0),
        .bus(bus0.master)
    );

    pc_gen #(
        .XLEN(32), .RESET_VECTOR(32'h0), .ALIGN_BITS(1), .INC(4)
    ) dut1 (
        .clk(clk), .rst(rst), .i_en(en1), .i_trap_vector(tv1),
        .o_epc(epc1), .o_misalign_fault(mf1), .o_bad_addr(bad1),
        .bus(bus1.master)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives the enable, handshake and redirect inputs of one instance.
    task automatic applyStimulus(input int inst, input logic en, input logic ready,
                                 input logic rv, input logic [1:0] mode,
                                 input logic [31:0] pcx, input logic [31:0] imm,
                                 input logic [31:0] reg1);
        if (inst == 0) begin
            en0               = en;
            bus0.fetch_ready  = ready;
            bus0.redir_valid  = rv;
            bus0.redir_mode   = mode;
            bus0.pc_execute   = pcx;
            bus0.imm          = imm;
            bus0.reg1         = reg1;
        end else begin
            en1               = en;
            bus1.fetch_ready  = ready;
            bus1.redir_valid  = rv;
            bus1.redir_mode   = mode;
            bus1.pc_execute   = pcx;
            bus1.imm          = imm;
            bus1.reg1         = reg1;
        end
    endtask

    // Queues the expected outputs for the current cycle; epc/bad_addr come
    // from the hand-tracked xEpc/xBad values.
    task automatic checkOutput(input string name, input int inst, input logic [31:0] addr,
                               input logic valid, input logic flush, input logic mf);
        exp_t x;
        x.name  = name;
        x.inst  = inst;
        x.addr  = addr;
        x.valid = valid;
        x.flush = flush;
        x.epc   = xEpc;
        x.bad   = xBad;
        x.mf    = mf;
        sbQ.push_back(x);
    endtask

    // Monitor: compares one queued expectation per falling edge.
    always @(negedge clk) begin
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            if (e.inst == 0) begin
                aAddr = bus0.fetch_addr; aValid = bus0.fetch_valid; aFlush = bus0.fetch_flush;
                aEpc  = epc0; aBad = bad0; aMf = mf0;
            end else begin
                aAddr = bus1.fetch_addr; aValid = bus1.fetch_valid; aFlush = bus1.fetch_flush;
                aEpc  = epc1; aBad = bad1; aMf = mf1;
            end
            checks = checks + 1;
            if (aAddr === e.addr && aValid === e.valid && aFlush === e.flush &&
                aEpc === e.epc && aBad === e.bad && aMf === e.mf) begin
                passes = passes + 1;
            end else begin
                $display("[TB] FAIL %s: got addr=%h valid=%b flush=%b epc=%h bad=%h mf=%b, want addr=%h valid=%b flush=%b epc=%h bad=%h mf=%b",
                         e.name, aAddr, aValid, aFlush, aEpc, aBad, aMf,
                         e.addr, e.valid, e.flush, e.epc, e.bad, e.mf);
            end
        end
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        checks = 0;
        passes = 0;
        xEpc   = 32'h0;
        xBad   = 32'h0;
        rst    = 1'b1;
        tv0    = 32'h80;
        tv1    = 32'h80;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 0, 32'h0, 1'b0, 1'b0, 1'b0);
        nextCycle();

        // Release and sequential fetch.
        rst = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("release", 0, 32'h0, 1'b0, 1'b0, 1'b0); nextCycle();
        checkOutput("seq0", 0, 32'h0, 1'b1, 1'b0, 1'b0); nextCycle();
        checkOutput("seq4", 0, 32'h4, 1'b1, 1'b0, 1'b0); nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("seq8", 0, 32'h8, 1'b1, 1'b0, 1'b0); nextCycle();
        checkOutput("hold8a", 0, 32'h8, 1'b1, 1'b0, 1'b0); nextCycle();
        checkOutput("hold8b", 0, 32'h8, 1'b1, 1'b0, 1'b0); nextCycle();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("hold8c", 0, 32'h8, 1'b1, 1'b0, 1'b0); nextCycle();
        checkOutput("seq12", 0, 32'hC, 1'b1, 1'b0, 1'b0); nextCycle();

        // Branch wins over an accepted handshake, then JALR clears bit 0.
        applyStimulus(0, 1'b1, 1'b1, 1'b1, M_BR, 32'h100, 32'h20, 32'h0);
        checkOutput("branch", 0, 32'h10, 1'b1, 1'b1, 1'b0); nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("branchTgt", 0, 32'h120, 1'b1, 1'b0, 1'b0); nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 1'b1, M_JALR, 32'h0, 32'h0, 32'h201);
        checkOutput("jalr", 0, 32'h120, 1'b1, 1'b1, 1'b0); nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("jalrTgt", 0, 32'h200, 1'b1, 1'b0, 1'b0); nextCycle();

        // Redirect captured during a stall and applied when enabled.
        applyStimulus(0, 1'b0, 1'b0, 1'b1, M_BR, 32'h3F0, 32'h10, 32'h0);
        checkOutput("stallCap", 0, 32'h200, 1'b1, 1'b0, 1'b0); nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stallHold", 0, 32'h200, 1'b1, 1'b0, 1'b0); nextCycle();
        end
        applyStimulus(0, 1'b1, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("pendApply", 0, 32'h200, 1'b1, 1'b1, 1'b0); nextCycle();
        checkOutput("pendTgt", 0, 32'h400, 1'b1, 1'b0, 1'b0); nextCycle();

        // A newer stalled redirect overwrites the older one.
        applyStimulus(0, 1'b0, 1'b0, 1'b1, M_BR, 32'h3F0, 32'h10, 32'h0);
        checkOutput("stall2a", 0, 32'h400, 1'b1, 1'b0, 1'b0); nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 1'b1, M_BR, 32'h4F0, 32'h10, 32'h0);
        checkOutput("stall2b", 0, 32'h400, 1'b1, 1'b0, 1'b0); nextCycle();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("stall2c", 0, 32'h400, 1'b1, 1'b0, 1'b0); nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("pend2Apply", 0, 32'h400, 1'b1, 1'b1, 1'b0); nextCycle();
        checkOutput("pend2Tgt", 0, 32'h500, 1'b1, 1'b0, 1'b0); nextCycle();

        // Live redirect beats a pending one, and the pending slot is dropped.
        applyStimulus(0, 1'b0, 1'b0, 1'b1, M_BR, 32'h600, 32'h0, 32'h0);
        checkOutput("pend3Cap", 0, 32'h500, 1'b1, 1'b0, 1'b0); nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 1'b1, M_BR, 32'h700, 32'h0, 32'h0);
        checkOutput("liveWins", 0, 32'h500, 1'b1, 1'b1, 1'b0); nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("liveTgt", 0, 32'h700, 1'b1, 1'b0, 1'b0); nextCycle();
        checkOutput("pendCleared", 0, 32'h700, 1'b1, 1'b0, 1'b0); nextCycle();

        // Misaligned BRANCH and JALR targets trap.
        applyStimulus(0, 1'b1, 1'b0, 1'b1, M_BR, 32'h100, 32'h2, 32'h0);
        checkOutput("misBr", 0, 32'h700, 1'b1, 1'b1, 1'b0); nextCycle();
        xEpc = 32'h100; xBad = 32'h102;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("misBrTrap", 0, 32'h80, 1'b1, 1'b0, 1'b1); nextCycle();
        checkOutput("misBrClr", 0, 32'h80, 1'b1, 1'b0, 1'b0); nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 1'b1, M_JALR, 32'h120, 32'h0, 32'h107);
        checkOutput("misJalr", 0, 32'h80, 1'b1, 1'b1, 1'b0); nextCycle();
        xEpc = 32'h120; xBad = 32'h106;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("misJalrTrap", 0, 32'h80, 1'b1, 1'b0, 1'b1); nextCycle();

        // TRAP saves epc, MRET returns to it.
        tv0 = 32'h90;
        applyStimulus(0, 1'b1, 1'b0, 1'b1, M_TRAP, 32'h44, 32'h0, 32'h0);
        checkOutput("trap", 0, 32'h80, 1'b1, 1'b1, 1'b0); nextCycle();
        xEpc = 32'h44;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("trapTgt", 0, 32'h90, 1'b1, 1'b0, 1'b0); nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 1'b1, M_MRET, 32'h0, 32'h0, 32'h0);
        checkOutput("mret", 0, 32'h90, 1'b1, 1'b1, 1'b0); nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("mretTgt", 0, 32'h44, 1'b1, 1'b0, 1'b0); nextCycle();

        // Sequential wrap past the top of the address space.
        applyStimulus(0, 1'b1, 1'b0, 1'b1, M_BR, 32'hFFFF_FFF0, 32'hC, 32'h0);
        checkOutput("wrapBr", 0, 32'h44, 1'b1, 1'b1, 1'b0); nextCycle();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("wrapTop", 0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0); nextCycle();
        checkOutput("wrapZero", 0, 32'h0, 1'b1, 1'b0, 1'b0); nextCycle();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("wrapFour", 0, 32'h4, 1'b1, 1'b0, 1'b0); nextCycle();

        // Asynchronous reset discards a pending redirect.
        applyStimulus(0, 1'b0, 1'b0, 1'b1, M_BR, 32'h300, 32'h0, 32'h0);
        checkOutput("rstCap", 0, 32'h4, 1'b1, 1'b0, 1'b0); nextCycle();
        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        xEpc = 32'h0; xBad = 32'h0;
        checkOutput("rstAsync", 0, 32'h0, 1'b0, 1'b0, 1'b0); nextCycle();
        rst = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("rstRelease", 0, 32'h0, 1'b0, 1'b0, 1'b0); nextCycle();
        checkOutput("rstNoStale", 0, 32'h0, 1'b1, 1'b0, 1'b0); nextCycle();
        checkOutput("rstNoStale2", 0, 32'h0, 1'b1, 1'b0, 1'b0); nextCycle();

        // ALIGN_BITS = 1: 0x102 is legal, 0x101 still traps.
        applyStimulus(1, 1'b1, 1'b0, 1'b1, M_BR, 32'h100, 32'h2, 32'h0);
        checkOutput("a1Br", 1, 32'h0, 1'b1, 1'b1, 1'b0); nextCycle();
        applyStimulus(1, 1'b1, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("a1Tgt", 1, 32'h102, 1'b1, 1'b0, 1'b0); nextCycle();
        applyStimulus(1, 1'b1, 1'b0, 1'b1, M_BR, 32'h100, 32'h1, 32'h0);
        checkOutput("a1Mis", 1, 32'h102, 1'b1, 1'b1, 1'b0); nextCycle();
        xEpc = 32'h100; xBad = 32'h101;
        applyStimulus(1, 1'b1, 1'b0, 1'b0, M_BR, 32'h0, 32'h0, 32'h0);
        checkOutput("a1Trap", 1, 32'h80, 1'b1, 1'b0, 1'b1); nextCycle();

        // Every queued expectation must have been consumed by the monitor.
        nextCycle();
        checks = checks + 1;
        if (sbQ.size() == 0) begin
            passes = passes + 1;
        end else begin
            $display("[TB] FAIL drain: got %0d entries left, want 0", sbQ.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
